mtx_stream_decoder: RTL and testbench

Parametrised, double-buffered decoder for serial matrix transmission. It assembles a DIM×DIM complex gate matrix from a stream of signed cells into a shadow buffer. Once every cell of a frame has arrived, it transfers the frame to an output bank and holds it under a valid/ack handshake. It sits between the matrix transmission link and the gate-application datapath, and extends single-qubit 2×2 decoding to multi-qubit gates with flow control and frame integrity checking.

---
 rtl/mtx_stream_decoder.sv | 158 +++++++++++++++
 tb/tb_mtx_stream_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_stream_decoder.sv
// mtx_stream_decoder
//   Double-buffered decoder for a serial matrix link. Signed cells are
//   collected in any order into a shadow buffer. A bitmap records which slots
//   have arrived. When the last slot of a frame arrives, the frame is copied
//   to the output bank and held under a valid/ack handshake. If the bank is
//   still occupied, the decoder stalls in PEND until the consumer acks.
//
//   Optional build macro: MTX_DEC_DUP_CHECK_EN
//     defined   -> err_dup flags any cell written twice within one frame
//     undefined -> err_dup is tied low and duplicates silently overwrite
//
//   Ports
//     clk           rising-edge clock
//     reset         asynchronous active-low reset
//     cell_data     signed cell value (WIDTH bits)
//     cell_imag     1 = imaginary part, 0 = real part
//     cell_row      row index (IW bits)
//     cell_col      column index (IW bits)
//     cell_valid    a cell is presented this cycle
//     cell_ready    decoder accepts cells (registered, equals state FILL)
//     frame_abort   discard the partially received frame
//     matrix_flat   output bank, element (r,c,i) at [((r*DIM+c)*2+i)*WIDTH +: WIDTH]
//     matrix_valid  output bank holds an unconsumed matrix
//     matrix_ack    consumer has taken the output bank
//     err_dup       sticky duplicate-cell flag
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | collecting cells; cell_ready = 1
//   PEND  | complete frame waiting for a free bank; shadow frozen
module mtx_stream_decoder #(
  parameter  int WIDTH = 19,
  parameter  int DIM   = 2,
  localparam int IW    = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          cell_data,
  input  logic                      cell_imag,
  input  logic [IW-1:0]             cell_row,
  input  logic [IW-1:0]             cell_col,
  input  logic                      cell_valid,
  output logic                      cell_ready,
  input  logic                      frame_abort,
  output logic [2*DIM*DIM*WIDTH-1:0] matrix_flat,
  output logic                      matrix_valid,
  input  logic                      matrix_ack,
  output logic                      err_dup
);

  localparam int NSLOT = 2*DIM*DIM;
  localparam int SW    = $clog2(NSLOT);

  typedef enum logic {S_FILL = 1'b0, S_PEND = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [NSLOT-1:0]         bitmap_q, bitmap_d, bitmap_acc;
  logic [NSLOT*WIDTH-1:0]   shadow_q, shadow_d;
  logic [NSLOT*WIDTH-1:0]   matrix_flat_q, matrix_flat_d;
  logic                     matrix_valid_q, matrix_valid_d;

  logic [SW-1:0]            slot;
  logic                     fill_st;
  logic                     accept;
  logic                     complete;
  logic                     bank_free;
  logic                     xfer;

  // DIM is a power of two, so the linear slot index is a plain concatenation.
  assign slot      = {cell_row, cell_col, cell_imag};
  assign fill_st   = (state_q == S_FILL);
  assign accept    = cell_valid && fill_st && !frame_abort;
  assign bank_free = !matrix_valid_q || matrix_ack;

  // Shadow write and bitmap update for the cell accepted this cycle.
  always_comb begin
    shadow_d   = shadow_q;
    bitmap_acc = bitmap_q;
    if (accept) begin
      shadow_d[slot*WIDTH +: WIDTH] = cell_data;
      bitmap_acc[slot]              = 1'b1;
    end
  end

  assign complete = accept && (&bitmap_acc);

  // Abort wins over a pending transfer even when ack is present.
  // In PEND no cell is accepted, so shadow_d equals the frozen shadow_q.
  assign xfer = fill_st ? (complete && bank_free)
                        : (!frame_abort && matrix_ack && matrix_valid_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (frame_abort) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL:  if (complete && !bank_free)       state_d = S_PEND;
        S_PEND:  if (matrix_ack && matrix_valid_q) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cell_ready = (state_q == S_FILL);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    bitmap_d       = (frame_abort || xfer) ? '0 : bitmap_acc;
    matrix_flat_d  = xfer ? shadow_d : matrix_flat_q;
    matrix_valid_d = matrix_valid_q;
    if (xfer)            matrix_valid_d = 1'b1;
    else if (matrix_ack) matrix_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap_q       <= '0;
      shadow_q       <= '0;
      matrix_flat_q  <= '0;
      matrix_valid_q <= 1'b0;
    end else begin
      bitmap_q       <= bitmap_d;
      shadow_q       <= shadow_d;
      matrix_flat_q  <= matrix_flat_d;
      matrix_valid_q <= matrix_valid_d;
    end
  end

  assign matrix_flat  = matrix_flat_q;
  assign matrix_valid = matrix_valid_q;

`ifdef MTX_DEC_DUP_CHECK_EN
  logic err_dup_q, err_dup_d;

  assign err_dup_d = err_dup_q || (accept && bitmap_q[slot]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_dup_q <= 1'b0;
    else        err_dup_q <= err_dup_d;
  end

  assign err_dup = err_dup_q;
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_mtx_stream_decoder.sv
module tb_mtx_stream_decoder;

  localparam int W  = 19;
  localparam int D  = 2;
  localparam int N  = 2*D*D;
  localparam int W4 = 12;
  localparam int D4 = 4;
  localparam int N4 = 2*D4*D4;

  logic clk;
  logic reset;

  // DIM=2 instance signals
  logic [W-1:0]   cd;
  logic           ci, cv, ab, ak;
  logic [0:0]     cr, cc;
  logic           rdy, mval, dup;
  logic [N*W-1:0] flat;

  // DIM=4 instance signals
  logic [W4-1:0]    cd4;
  logic             ci4, cv4, ab4, ak4;
  logic [1:0]       cr4, cc4;
  logic             rdy4, mval4, dup4;
  logic [N4*W4-1:0] flat4;

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  // Reference model: a frame is a set of received slots plus shadow values.
  logic [W-1:0] m_shadow[N];
  logic [W-1:0] m_bank[N];
  bit           m_got[N];
  bit           m_valid, m_pend, m_dup;

  mtx_stream_decoder #(.WIDTH(W), .DIM(D)) u_dut (
    .clk(clk), .reset(reset), .cell_data(cd), .cell_imag(ci), .cell_row(cr),
    .cell_col(cc), .cell_valid(cv), .cell_ready(rdy), .frame_abort(ab),
    .matrix_flat(flat), .matrix_valid(mval), .matrix_ack(ak), .err_dup(dup)
  );

  mtx_stream_decoder #(.WIDTH(W4), .DIM(D4)) u_dut4 (
    .clk(clk), .reset(reset), .cell_data(cd4), .cell_imag(ci4), .cell_row(cr4),
    .cell_col(cc4), .cell_valid(cv4), .cell_ready(rdy4), .frame_abort(ab4),
    .matrix_flat(flat4), .matrix_valid(mval4), .matrix_ack(ak4), .err_dup(dup4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; int slot; int val; bit abort; bit ack;
    bit exp_valid; bit exp_ready;
  } vec_t;

  vec_t tab[10];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [N*W-1:0] act,
                          input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0; m_bank[k] = '0; m_got[k] = 1'b0;
    end
    m_valid = 1'b0; m_pend = 1'b0; m_dup = 1'b0;
  endtask

  task automatic model_check(input string tag);
    logic [N*W-1:0] exp;
    for (int k = 0; k < N; k++) exp[k*W +: W] = m_bank[k];
    chk({tag, ".ready"}, rdy, !m_pend);
    chk({tag, ".valid"}, mval, m_valid);
    chk({tag, ".err_dup"}, dup, m_dup);
    chk_flat({tag, ".flat"}, flat, exp);
  endtask

  function automatic logic signed [63:0] elem(input int k);
    return $signed(flat[k*W +: W]);
  endfunction

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input string tag, input bit v, input int slot,
                      input int val, input bit abort, input bit ack);
    logic [2:0] s;
    bit full, prev;
    s = slot[2:0];
    @(negedge clk);
    cv = v; ci = s[0]; cc = s[1]; cr = s[2]; cd = val[W-1:0];
    ab = abort; ak = ack;
    prev = mval;
    @(posedge clk);
    if (abort) begin
      for (int k = 0; k < N; k++) m_got[k] = 1'b0;
      m_pend = 1'b0;
      if (ack) m_valid = 1'b0;
    end else if (m_pend) begin
      if (ack && m_valid) begin
        m_bank = m_shadow;
        for (int k = 0; k < N; k++) m_got[k] = 1'b0;
        m_pend = 1'b0;
      end
    end else begin
      full = 1'b0;
      if (v) begin
`ifdef MTX_DEC_DUP_CHECK_EN
        if (m_got[s]) m_dup = 1'b1;
`endif
        m_shadow[s] = val[W-1:0];
        m_got[s]    = 1'b1;
        full = 1'b1;
        for (int k = 0; k < N; k++) if (!m_got[k]) full = 1'b0;
      end
      if (full) begin
        if (!m_valid || ack) begin
          m_bank  = m_shadow;
          m_valid = 1'b1;
          for (int k = 0; k < N; k++) m_got[k] = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (ack) begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (!prev && mval) rises++;
    model_check(tag);
  endtask

  initial begin
    int perm[N4];
    logic signed [W4-1:0] e4[N4];
    logic [4:0] s4;
    int r, t, j;

    tab[0] = '{v:0, slot:0, val:0, abort:0, ack:1, exp_valid:0, exp_ready:1};
    for (int k = 0; k < N; k++)
      tab[k+1] = '{v:1, slot:k, val:k, abort:0, ack:0, exp_valid:(k == N-1), exp_ready:1};
    tab[9] = '{v:0, slot:0, val:0, abort:0, ack:1, exp_valid:0, exp_ready:1};

    reset = 1'b0;
    cv = 0; ci = 0; cc = 0; cr = 0; cd = '0; ab = 0; ak = 0;
    cv4 = 0; ci4 = 0; cc4 = '0; cr4 = '0; cd4 = '0; ab4 = 0; ak4 = 0;
    model_reset();
    #12;
    model_check("reset");
    chk("reset.ready4", rdy4, 1);
    chk("reset.valid4", mval4, 0);
    chk("reset.flat4_zero", (flat4 == '0), 1);
    @(negedge clk); reset = 1'b1;

    // In-order frame from the vector table
    for (int i = 0; i < 10; i++) begin
      step("tab", tab[i].v, tab[i].slot, tab[i].val, tab[i].abort, tab[i].ack);
      chk($sformatf("tab%0d.valid", i), mval, tab[i].exp_valid);
      chk($sformatf("tab%0d.ready", i), rdy, tab[i].exp_ready);
    end
    for (int k = 0; k < N; k++) chk($sformatf("inorder.elem%0d", k), elem(k), k);

    // Reverse-order frame, no ack, then a second frame stalls in PEND
    for (int i = 0; i < N; i++) step("rev", 1, N-1-i, -(i+1), 0, 0);
    chk("rev.valid", mval, 1);
    chk("rev.elem7", elem(7), -1);
    chk("rev.elem0", elem(0), -8);
    for (int k = 0; k < N; k++) step("second", 1, k, 100+k, 0, 0);
    chk("pend.ready_low", rdy, 0);
    chk("pend.bank_old", elem(0), -8);
    step("pend_idle", 1, 0, 999, 0, 0);
    step("pend_idle", 1, 0, 999, 0, 0);
    chk("pend.still_low", rdy, 0);
    step("pend_ack", 0, 0, 0, 0, 1);
    chk("pend_ack.elem0", elem(0), 100);
    chk("pend_ack.valid", mval, 1);
    chk("pend_ack.ready", rdy, 1);
    step("clr", 0, 0, 0, 0, 1);
    chk("clr.valid", mval, 0);

    // Abort with a cell in the same cycle, then a fresh frame
    rises = 0;
    for (int k = 0; k < 5; k++) step("abort_pre", 1, k, 55, 0, 0);
    step("abort", 1, 5, 77, 1, 0);
    for (int k = 0; k < N; k++) step("fresh", 1, k, 200+k, 0, 0);
    chk("abort.rises", rises, 1);
    chk("abort.elem0", elem(0), 200);
    chk("abort.elem5", elem(5), 205);
    chk("abort.err_dup", dup, 0);
    step("clr", 0, 0, 0, 0, 1);

    // Duplicate cell at slot (0,1,imag) = 3
    step("dup", 1, 3, 5, 0, 0);
    step("dup", 1, 3, 9, 0, 0);
    for (int k = 0; k < N; k++) if (k != 3) step("dup_rest", 1, k, 40+k, 0, 0);
    chk("dup.valid", mval, 1);
    chk("dup.slot3", elem(3), 9);
`ifdef MTX_DEC_DUP_CHECK_EN
    chk("dup.flag_on", dup, 1);
`else
    chk("dup.flag_off", dup, 0);
`endif
    step("clr", 0, 0, 0, 0, 1);

    // Asynchronous reset while PEND
    for (int k = 0; k < N; k++) step("rstA", 1, k, 300+k, 0, 0);
    for (int k = 0; k < N; k++) step("rstB", 1, k, 400+k, 0, 0);
    chk("rst.pend", rdy, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    model_reset();
    model_check("rst_async");
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < N; k++) step("clean", 1, N-1-k, 600+k, 0, 0);
    chk("clean.elem7", elem(7), 600);
    chk("clean.elem0", elem(0), 607);
    step("clr", 0, 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, N-1),
           int'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));

    // DIM=4, WIDTH=12: shuffled frame with extreme values
    for (int k = 0; k < N4; k++) perm[k] = k;
    for (int k = N4-1; k > 0; k--) begin
      j = $urandom_range(0, k);
      t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < N4; k++) begin
      r = $urandom_range(0, 2);
      e4[k] = (r == 0) ? -12'sd2048 : (r == 1) ? 12'sd2047 : W4'($urandom);
    end
    for (int k = 0; k < N4; k++) begin
      s4 = perm[k][4:0];
      @(negedge clk);
      cv4 = 1'b1; ci4 = s4[0]; cc4 = s4[2:1]; cr4 = s4[4:3]; cd4 = e4[s4];
      @(posedge clk); #1;
      if (k == N4-2) chk("d4.valid_early", mval4, 0);
    end
    @(negedge clk); cv4 = 1'b0;
    chk("d4.valid", mval4, 1);
    chk("d4.ready", rdy4, 1);
    for (int k = 0; k < N4; k++)
      chk($sformatf("d4.elem%0d", k), $signed(flat4[k*W4 +: W4]), e4[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
